// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle multiply/divide sequencer for the execute stage.
// Runs one MULT/MULTU/DIV/DIVU at a time and holds {hi,lo} until consumed.
//   clk, resetn           : clock (rising edge), async active-low reset
//   req_valid/req_ready   : request handshake; req_op 00 mult 01 multu 10 div 11 divu
//   req_src1/req_src2     : rs (dividend/multiplicand), rt (divisor/multiplier)
//   cancel                : flush, aborts any in-flight op or held result
//   busy                  : op in flight or result held
//   resp_valid/resp_ready : result handshake; resp_hi = product hi / remainder,
//                           resp_lo = product lo / quotient
module muldiv_sched #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  input  logic        cancel,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  input  logic        resp_ready
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  // The result register is the last multiplier stage, so only MUL_LAT-1
  // intermediate stages are needed (at least one slot is declared).
  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  state_t state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [PD-1:0][63:0] mul_pipe_q, mul_pipe_d;

  logic        accept;
  logic        req_s1, req_s2;
  logic        sign1, sign2;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_prod;
  logic [63:0] mul_out;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  assign accept = (state_q == S_IDLE) && req_valid && !cancel;

  // 33-bit operands (sign- or zero-extended); the low 64 bits of the
  // 33x33 product are the exact 64-bit result.
  assign mul_a    = $signed({~op_q[0] & a_q[31], a_q});
  assign mul_b    = $signed({~op_q[0] & b_q[31], b_q});
  assign mul_prod = mul_a * mul_b;

  generate
    if (MUL_LAT == 1) begin : g_mul1
      assign mul_out = mul_prod;
    end else begin : g_muln
      assign mul_out = mul_pipe_q[PD-1];
    end
  endgenerate

  always_comb begin
    mul_pipe_d    = mul_pipe_q;
    mul_pipe_d[0] = mul_prod;
    for (int k = 1; k < PD; k++) mul_pipe_d[k] = mul_pipe_q[k-1];
  end

  // Restoring step: shift in next dividend bit, subtract if it fits.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};

  assign req_s1 = ~req_op[0] & req_src1[31];
  assign req_s2 = ~req_op[0] & req_src2[31];
  assign sign1  = ~op_q[0] & a_q[31];
  assign sign2  = ~op_q[0] & b_q[31];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = req_op[1] ? S_DIV : S_MUL;
      S_MUL:  if (cancel) state_d = S_IDLE;
              else if (cnt_q == 6'(MUL_LAT)) state_d = S_DONE;
      S_DIV:  if (cancel) state_d = S_IDLE;
              else if (cnt_q == 6'(DIV_ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = cancel ? S_IDLE : S_DONE;
      // cancel wins over a same-cycle resp_ready; result counts as not taken
      S_DONE: if (cancel || resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == S_IDLE) && resetn;
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_DONE);
    resp_hi    = hi_q;
    resp_lo    = lo_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d  = req_op;
        a_d   = req_src1;
        b_d   = req_src2;
        cnt_d = req_op[1] ? 6'd0 : 6'd1;
        rem_d = '0;
        // magnitudes for div; |0x80000000| still fits as unsigned
        quo_d = req_s1 ? -req_src1 : req_src1;
        dvs_d = req_s2 ? -req_src2 : req_src2;
      end
      S_MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MUL_LAT) && !cancel) begin
          hi_d = mul_out[63:32];
          lo_d = mul_out[31:0];
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 6'd1;
        if (!diff[33]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      S_FIX: if (!cancel) begin
        if (dvs_q == '0) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = (sign1 ^ sign2) ? -quo_q : quo_q;
          hi_d = sign1 ? -rem_q : rem_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_pipe_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_pipe_q <= mul_pipe_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: scoreboard queue of expected {hi,lo}
// filled at issue and drained by a response monitor, plus latency,
// back-pressure, cancel and async-reset checks.
module tb_muldiv_sched;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        req_ready;
  logic        cancel;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_hi, resp_lo;
  logic        resp_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  muldiv_sched #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
    .cancel(cancel), .busy(busy),
    .resp_valid(resp_valid), .resp_hi(resp_hi), .resp_lo(resp_lo),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Consumed results are compared against the scoreboard head.
  always @(negedge clk) begin
    if (resetn && resp_valid && resp_ready && !cancel) begin
      if (sb_q.size() == 0) chk("sb_unexpected_resp", 1'b1, 1'b0);
      else chk("resp_data", {resp_hi, resp_lo}, sb_q.pop_front());
    end
  end

  // Drive a request at negedge, optionally push its expectation; returns
  // #1 after the accept edge (cycle 0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    chk("req_ready_at_issue", req_ready, 1'b1);
    if (push) sb_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_src1 = $urandom; req_src2 = $urandom;  // must be ignored once latched
  endtask

  task automatic wait_lat(input int exp_lat, input string tag);
    int n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    issue(op, a, b, exp, 1'b1);
    wait_lat(op[1] ? DIV_LAT : MUL_LAT, op[1] ? "div_latency" : "mul_latency");
    @(posedge clk); #1;
    chk("idle_after_consume", {resp_valid, busy}, 2'b00);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int never;
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    cancel = 1'b0; resp_ready = 1'b1;
    #2;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hilo", {resp_hi, resp_lo}, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);

    // directed cases
    run_op(2'b11, 32'd7, 32'd2, {32'd1, 32'd3});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
    run_op(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op(2'b11, 32'h8000_0003, 32'd0, {32'h8000_0003, 32'hFFFF_FFFF});
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2});

    // random ops against the model
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb));
    end

    // back-pressure, then second op waiting in req_valid during DONE
    resp_ready = 1'b0;
    issue(2'b01, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    wait_lat(MUL_LAT, "bp_latency");
    req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'hFFFF_FFFD; req_src2 = 32'd7;
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", resp_valid, 1'b1);
      chk("bp_data_stable", {resp_hi, resp_lo}, {32'd0, 32'd15});
      chk("bp_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_consume", {resp_valid, busy, req_ready}, 3'b001);
    @(posedge clk); #1;
    chk("b2b_accepted", busy, 1'b1);
    req_valid = 1'b0;
    wait_lat(MUL_LAT, "b2b_latency");
    @(posedge clk); #1;

    // cancel in DONE with resp_ready: cancel wins, nothing consumed
    resp_ready = 1'b0;
    issue(2'b11, 32'd9, 32'd4, 64'd0, 1'b0);
    wait_lat(DIV_LAT, "cancel_done_latency");
    cancel = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("cancel_done_idle", {resp_valid, busy}, 2'b00);
    cancel = 1'b0;

    // cancel at cycle 10 of a divide
    issue(2'b10, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    chk("cancel_div_idle", {resp_valid, busy}, 2'b00);
    cancel = 1'b0;
    never = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid) never++;
    end
    chk("cancel_div_no_resp", 64'(never), 64'd0);

    // cancel with req_valid in IDLE: no accept
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; cancel = 1'b1;
    @(posedge clk); #1;
    chk("cancel_idle_no_accept", busy, 1'b0);
    req_valid = 1'b0; cancel = 1'b0;

    // stale nonzero hi/lo, then reset mid-multiply
    run_op(2'b01, 32'h1234_5678, 32'h10, model(2'b01, 32'h1234_5678, 32'h10));
    issue(2'b00, 32'd11, 32'd13, 64'd0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    chk("midrst_busy_valid", {busy, resp_valid}, 2'b00);
    chk("midrst_hilo", {resp_hi, resp_lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("midrst_req_ready", req_ready, 1'b1);
    run_op(2'b00, 32'd11, 32'd13, {32'd0, 32'd143});

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
